pe_feeder: RTL and testbench
============================

PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 SHALL have parameter DW, default 16, operand width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, entries per operand buffer.
REQ-003 SHALL have parameter AW, default 4, buffer address width (log2 DEPTH).
REQ-004 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  reset, one clock; reset is synchronous and active-high.
REQ-006 SHALL have port max_cntr  input  8  vector length N for the run.
REQ-007 SHALL have port ld_we  input  1  buffer write strobe.
REQ-008 SHALL have port ld_sel  input  1  buffer select: 0 = A, 1 = B.
REQ-009 SHALL have port ld_addr  input  AW  buffer write index.
REQ-010 SHALL have port ld_data  input  DW  signed operand write data.
REQ-011 SHALL have port go  input  1  run request, sampled only in IDLE.
REQ-012 SHALL have port aff  input  1  PE A-FIFO full; blocks A strobes.
REQ-013 SHALL have port bff  input  1  PE B-FIFO full; blocks B strobes.
REQ-014 SHALL have port start  output  1  one-cycle start pulse to the PE.
REQ-015 SHALL have port awe  output  1  A write strobe to the PE.
REQ-016 SHALL have port bwe  output  1  B write strobe to the PE.
REQ-017 SHALL have port a_out  output  DW  signed A operand to PE a_in.
REQ-018 SHALL have port b_out  output  DW  signed B operand to PE b_in.
REQ-019 SHALL have port busy  output  1  high in every state except IDLE.
REQ-020 SHALL have port done  output  1  one-cycle run-complete pulse.

Function
REQ-021 SHALL hold two DEPTH x DW buffers (A, B); ld_we in IDLE writes ld_data to buffer[ld_sel][ld_addr] at the clock edge; ld_we while busy is ignored.
REQ-022 SHALL implement the FSM states IDLE, START, SEND_A, SEND_B, DONE.
REQ-023 IDLE: go=1 and max_cntr!=0 -> START, latching N = min(max_cntr, DEPTH) and clearing idx to 0; go with max_cntr=0 is ignored (state remains IDLE).
REQ-024 START: start=1 for exactly this cycle -> SEND_A.
REQ-025 SEND_A: aff=0 -> awe=1, a_out=A[idx], -> SEND_B; aff=1 -> awe=0, state held.
REQ-026 SEND_B: bff=0 -> bwe=1, b_out=B[idx]; idx==N-1 -> DONE, else idx+1 and -> SEND_A; bff=1 -> bwe=0, state and idx held.
REQ-027 DONE: done=1 for exactly this cycle -> IDLE.
REQ-028 awe/bwe SHALL be combinational (state AND NOT full); a_out/b_out SHALL be 0 whenever their strobe is 0.
REQ-029 awe and bwe SHALL never be high in the same cycle; start SHALL never coincide with awe, bwe or done.
REQ-030 Unstalled timing, with go sampled at edge T: start is high in cycle T+1, strobes alternate A,B in cycles T+2..T+1+2N, done is high in cycle T+2+2N, and busy is high from T+1 to T+2+2N inclusive.
REQ-031 Each stall cycle (aff or bff high in the matching state) SHALL extend the run by exactly one cycle and SHALL NOT skip or repeat any operand.
REQ-032 go in the same cycle as ld_we in IDLE: the write SHALL land, and the run SHALL use the new value.
REQ-033 go while busy SHALL be ignored; max_cntr changes while busy SHALL NOT affect the latched N.

Reset
REQ-034 On rst=1 at a clock edge: state->IDLE, idx=0, N=0, and start, awe, bwe, a_out, b_out, busy, done all 0 from the next cycle.
REQ-035 Reset SHALL abort a run in progress immediately with no done pulse; buffer contents are not cleared by reset.

Verification
REQ-036 Load A={1,2,3,4}, B={5,6,7,8}, N=4, aff=bff=0, go at T -> start at T+1; a/b sequence 1,5,2,6,3,7,4,8 in cycles T+2..T+9; done at T+10.
REQ-037 Same load, aff=1 for 3 cycles while in SEND_A with idx=1 -> awe stays low 3 cycles, then a_out=2; done at T+13; sequence unchanged.
REQ-038 max_cntr=0 with go -> busy stays 0 and there are no strobes; max_cntr=20 with go -> exactly 16 A and 16 B strobes, done at T+34.
REQ-039 rst=1 during SEND_B at idx=2 -> all outputs 0 next cycle, no done pulse; a subsequent go replays from A[0] using the retained buffer data.
REQ-040 ld_we to A[0]=99 while busy, and a second go while busy -> both ignored; the next run outputs the original A[0], and only one done pulse occurs.

Source files
------------

// File: rtl/pe_feeder.sv
// Operand feeder for a processing element: buffers A and B vectors, then streams
// them as alternating A/B strobes with start/done framing and FIFO back-pressure.
module pe_feeder #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           max_cntr,
  input  logic                 ld_we,
  input  logic                 ld_sel,
  input  logic [AW-1:0]        ld_addr,
  input  logic signed [DW-1:0] ld_data,
  input  logic                 go,
  input  logic                 aff,
  input  logic                 bff,
  output logic                 start,
  output logic                 awe,
  output logic                 bwe,
  output logic signed [DW-1:0] a_out,
  output logic signed [DW-1:0] b_out,
  output logic                 busy,
  output logic                 done
);

  // Length counter is one bit wider than max_cntr so DEPTH=256 still fits.
  localparam int unsigned CW = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND_A,
    S_SEND_B,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [AW-1:0]         idx_q;
  logic [CW-1:0]         n_q;
  logic                  start_q;
  logic                  done_q;
  logic                  busy_q;

  logic signed [DW-1:0]  mem_a [DEPTH];
  logic signed [DW-1:0]  mem_b [DEPTH];

  logic [CW-1:0]         req_len_c;
  logic [CW-1:0]         n_clamp_c;
  logic                  last_c;
  logic                  load_en_c;

  assign req_len_c = CW'(max_cntr);
  assign n_clamp_c = (req_len_c > CW'(DEPTH)) ? CW'(DEPTH) : req_len_c;
  assign last_c    = (CW'(idx_q) == (n_q - CW'(1)));
  assign load_en_c = ld_we && (state_q == S_IDLE);

  // Operand buffers: writable only while idle, never cleared by reset.
  always_ff @(posedge clk) begin
    if (load_en_c) begin
      if (ld_sel) begin
        mem_b[ld_addr] <= ld_data;
      end else begin
        mem_a[ld_addr] <= ld_data;
      end
    end
  end

  // Run sequencer; start/done/busy are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go && (max_cntr != 8'd0)) begin
            state_q <= S_START;
            n_q     <= n_clamp_c;
            idx_q   <= '0;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          state_q <= S_SEND_A;
        end
        S_SEND_A: begin
          if (!aff) begin
            state_q <= S_SEND_B;
          end
        end
        S_SEND_B: begin
          if (!bff) begin
            if (last_c) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + AW'(1);
              state_q <= S_SEND_A;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Strobes follow the FIFO full flags within the same cycle.
  assign awe   = (state_q == S_SEND_A) && !aff;
  assign bwe   = (state_q == S_SEND_B) && !bff;
  assign a_out = awe ? mem_a[idx_q] : '0;
  assign b_out = bwe ? mem_b[idx_q] : '0;

  assign start = start_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: a negedge monitor logs strobes and framing,
// and each scenario compares the log against hand-derived values.
module tb_pe_feeder;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [7:0]           max_cntr;
  logic                 ld_we;
  logic                 ld_sel;
  logic [AW-1:0]        ld_addr;
  logic signed [DW-1:0] ld_data;
  logic                 go;
  logic                 aff;
  logic                 bff;
  logic                 start;
  logic                 awe;
  logic                 bwe;
  logic signed [DW-1:0] a_out;
  logic signed [DW-1:0] b_out;
  logic                 busy;
  logic                 done;

  pe_feeder #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .max_cntr(max_cntr),
    .ld_we(ld_we), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .go(go), .aff(aff), .bff(bff),
    .start(start), .awe(awe), .bwe(bwe), .a_out(a_out), .b_out(b_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  // Monitor: cycle numbering follows "go sampled at edge T -> start in cycle T+1".
  int start_cnt = 0, start_at = -1, done_cnt = 0, done_at = -1, busy_cnt = 0;
  int awe_cnt = 0, bwe_cnt = 0, viol = 0;
  int seq[$];
  int a_cyc[$];

  always @(negedge clk) begin
    if (start) begin start_cnt++; start_at = cyc + 1; end
    if (done)  begin done_cnt++;  done_at  = cyc + 1; end
    if (busy)  busy_cnt++;
    if (awe) begin awe_cnt++; seq.push_back(int'(a_out)); a_cyc.push_back(cyc + 1); end
    if (bwe) begin bwe_cnt++; seq.push_back(int'(b_out)); end
    if (awe && bwe) viol++;
    if (start && (awe || bwe || done)) viol++;
    if (!awe && (a_out != '0)) viol++;
    if (!bwe && (b_out != '0)) viol++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input int addr, input int data);
    ld_we   = 1'b1;
    ld_sel  = sel;
    ld_addr = AW'(addr);
    ld_data = DW'(data);
    step();
    ld_we   = 1'b0;
  endtask

  task automatic run_go(input int n, output int t);
    max_cntr = 8'(n);
    go       = 1'b1;
    t        = cyc + 1;
    step();
    go       = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    step();
    step();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_start"}, int'(start), 0);
    chk({tag, "_awe"},   int'(awe),   0);
    chk({tag, "_bwe"},   int'(bwe),   0);
    chk({tag, "_aout"},  int'(a_out), 0);
    chk({tag, "_bout"},  int'(b_out), 0);
    chk({tag, "_busy"},  int'(busy),  0);
    chk({tag, "_done"},  int'(done),  0);
  endtask

  task automatic chk_seq(input string tag, input int s0, input int n);
    int exp_v;
    chk({tag, "_len"}, seq.size() - s0, 2 * n);
    for (int i = 0; i < 2 * n; i++) begin
      exp_v = (i % 2 == 0) ? (i / 2 + 1) : (i / 2 + 5);
      if (s0 + i < seq.size()) chk($sformatf("%s_%0d", tag, i), seq[s0 + i], exp_v);
    end
  endtask

  initial begin
    int t, s0, ac0, d0, st0, b0, aw0, bw0;
    rst = 1'b1; max_cntr = '0; ld_we = 1'b0; ld_sel = 1'b0; ld_addr = '0;
    ld_data = '0; go = 1'b0; aff = 1'b0; bff = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    step();
    chk_quiet("reset");

    // Basic unstalled run, N=4.
    for (int i = 0; i < 4; i++) begin
      load(1'b0, i, i + 1);
      load(1'b1, i, i + 5);
    end
    s0 = seq.size(); ac0 = a_cyc.size(); d0 = done_cnt; st0 = start_cnt; b0 = busy_cnt;
    run_go(4, t);
    wait_done(100, d0);
    chk("t1_start_at", start_at, t + 1);
    chk("t1_first_a", (ac0 < a_cyc.size()) ? a_cyc[ac0] : -1, t + 2);
    chk("t1_done_at", done_at, t + 10);
    chk("t1_busy_cycles", busy_cnt - b0, 10);
    chk("t1_starts", start_cnt - st0, 1);
    chk_seq("t1_seq", s0, 4);

    // A-FIFO full for 3 cycles while sending A[1].
    s0 = seq.size(); ac0 = a_cyc.size(); d0 = done_cnt; b0 = busy_cnt;
    run_go(4, t);
    step(); step(); step();
    aff = 1'b1;
    step(); step(); step();
    aff = 1'b0;
    wait_done(100, d0);
    chk("t2_a1_at", (ac0 + 1 < a_cyc.size()) ? a_cyc[ac0 + 1] : -1, t + 7);
    chk("t2_done_at", done_at, t + 13);
    chk("t2_busy_cycles", busy_cnt - b0, 13);
    chk_seq("t2_seq", s0, 4);

    // Zero length is ignored.
    b0 = busy_cnt; aw0 = awe_cnt; bw0 = bwe_cnt; st0 = start_cnt;
    run_go(0, t);
    step(); step(); step();
    chk("t3_zero_busy", busy_cnt - b0, 0);
    chk("t3_zero_strobes", (awe_cnt - aw0) + (bwe_cnt - bw0), 0);
    chk("t3_zero_start", start_cnt - st0, 0);

    // Oversized length clamps to DEPTH; max_cntr change mid-run has no effect.
    aw0 = awe_cnt; bw0 = bwe_cnt; d0 = done_cnt;
    run_go(20, t);
    max_cntr = 8'd2;
    wait_done(200, d0);
    chk("t3_clamp_awe", awe_cnt - aw0, 16);
    chk("t3_clamp_bwe", bwe_cnt - bw0, 16);
    chk("t3_clamp_done_at", done_at, t + 34);

    // B-FIFO stall: one held B strobe adds one cycle.
    s0 = seq.size(); d0 = done_cnt;
    run_go(4, t);
    step(); step();
    bff = 1'b1;
    step();
    bff = 1'b0;
    wait_done(100, d0);
    chk("t3b_done_at", done_at, t + 11);
    chk_seq("t3b_seq", s0, 4);

    // Reset during SEND_B at idx=2 aborts without done.
    s0 = seq.size(); d0 = done_cnt;
    run_go(4, t);
    step(); step(); step(); step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_quiet("t4_abort");
    step(); step(); step(); step();
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_partial_len", seq.size() - s0, 6);
    s0 = seq.size(); d0 = done_cnt;
    run_go(4, t);
    wait_done(100, d0);
    chk("t4_replay_done_at", done_at, t + 10);
    chk_seq("t4_replay", s0, 4);

    // Load and go while busy are both ignored.
    s0 = seq.size(); d0 = done_cnt; st0 = start_cnt;
    run_go(4, t);
    step();
    ld_we = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = DW'(99); go = 1'b1;
    step();
    ld_we = 1'b0; go = 1'b0;
    wait_done(100, d0);
    step(); step(); step(); step(); step();
    chk("t5_one_done", done_cnt - d0, 1);
    chk("t5_one_start", start_cnt - st0, 1);
    chk("t5_a0_run", (s0 < seq.size()) ? seq[s0] : -1, 1);
    s0 = seq.size(); d0 = done_cnt;
    run_go(4, t);
    wait_done(100, d0);
    chk("t5_a0_next", (s0 < seq.size()) ? seq[s0] : -1, 1);

    // Load in the same cycle as go: the run sees the new value.
    s0 = seq.size(); d0 = done_cnt;
    ld_we = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = DW'(42);
    run_go(2, t);
    ld_we = 1'b0;
    wait_done(100, d0);
    chk("t6_new_a0", (s0 < seq.size()) ? seq[s0] : -1, 42);
    chk("t6_len", seq.size() - s0, 4);
    chk("t6_done_at", done_at, t + 6);

    chk("invariants", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
